// File: rtl/control.sv
// MIPS main control decoder at the ID stage.
// Opcode/funct decode is combinational; the control word is registered into ID/EX.
module control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       Jr_if,
    output logic       Bne_if,
    output logic       J_if,
    output logic [1:0] RegDst,
    output logic       ALUSrc,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Beq_if,
    output logic       Bgezal_if,
    output logic [2:0] ALUOp,
    output logic [1:0] EXTOp
);

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'b000000,
        OP_REGIMM  = 6'b000001,
        OP_J       = 6'b000010,
        OP_JAL     = 6'b000011,
        OP_BEQ     = 6'b000100,
        OP_BNE     = 6'b000101,
        OP_ORI     = 6'b001101,
        OP_LUI     = 6'b001111,
        OP_LW      = 6'b100011,
        OP_SW      = 6'b101011
    } opcode_e;

    typedef enum logic [5:0] {
        FN_SLL  = 6'b000000,
        FN_JR   = 6'b001000,
        FN_JALR = 6'b001001,
        FN_ADDU = 6'b100001,
        FN_SUBU = 6'b100011
    } funct_e;

    typedef enum logic [1:0] {
        DST_RT  = 2'b00,
        DST_RD  = 2'b01,
        DST_R31 = 2'b10
    } regdst_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10
    } wbsel_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_OR   = 3'b010,
        ALU_PASS = 3'b011
    } aluop_e;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_HIGH = 2'b10
    } extop_e;

    typedef struct packed {
        logic    jr;
        logic    bne;
        logic    j;
        regdst_e regdst;
        logic    alusrc;
        wbsel_e  memtoreg;
        logic    regwrite;
        logic    memwrite;
        logic    beq;
        logic    bgezal;
        aluop_e  aluop;
        extop_e  extop;
    } ctrl_t;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // Every unlisted op/funct falls through to the all-zero NOP word.
    always_comb begin
        ctrl_d = '0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU: begin
                        ctrl_d.regdst   = DST_RD;
                        ctrl_d.regwrite = 1'b1;
                        ctrl_d.aluop    = ALU_ADD;
                    end
                    FN_SUBU: begin
                        ctrl_d.regdst   = DST_RD;
                        ctrl_d.regwrite = 1'b1;
                        ctrl_d.aluop    = ALU_SUB;
                    end
                    FN_JR: begin
                        ctrl_d.jr = 1'b1;
                    end
                    FN_JALR: begin
                        ctrl_d.jr       = 1'b1;
                        ctrl_d.regdst   = DST_RD;
                        ctrl_d.memtoreg = WB_LINK;
                        ctrl_d.regwrite = 1'b1;
                    end
                    default: ctrl_d = '0;
                endcase
            end
            OP_ORI: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.aluop    = ALU_OR;
                ctrl_d.extop    = EXT_ZERO;
            end
            OP_LW: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memtoreg = WB_MEM;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.aluop    = ALU_ADD;
                ctrl_d.extop    = EXT_SIGN;
            end
            OP_SW: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memwrite = 1'b1;
                ctrl_d.aluop    = ALU_ADD;
                ctrl_d.extop    = EXT_SIGN;
            end
            OP_LUI: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.aluop    = ALU_PASS;
                ctrl_d.extop    = EXT_HIGH;
            end
            OP_BEQ: begin
                ctrl_d.beq   = 1'b1;
                ctrl_d.aluop = ALU_SUB;
                ctrl_d.extop = EXT_SIGN;
            end
            OP_BNE: begin
                ctrl_d.bne   = 1'b1;
                ctrl_d.aluop = ALU_SUB;
                ctrl_d.extop = EXT_SIGN;
            end
            OP_J: begin
                ctrl_d.j = 1'b1;
            end
            OP_JAL: begin
                ctrl_d.j        = 1'b1;
                ctrl_d.regdst   = DST_R31;
                ctrl_d.memtoreg = WB_LINK;
                ctrl_d.regwrite = 1'b1;
            end
            // Link is written unconditionally; the branch unit resolves the condition.
            OP_REGIMM: begin
                ctrl_d.bgezal   = 1'b1;
                ctrl_d.extop    = EXT_SIGN;
                ctrl_d.regdst   = DST_R31;
                ctrl_d.memtoreg = WB_LINK;
                ctrl_d.regwrite = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign Jr_if     = ctrl_q.jr;
    assign Bne_if    = ctrl_q.bne;
    assign J_if      = ctrl_q.j;
    assign RegDst    = ctrl_q.regdst;
    assign ALUSrc    = ctrl_q.alusrc;
    assign MemtoReg  = ctrl_q.memtoreg;
    assign RegWrite  = ctrl_q.regwrite;
    assign MemWrite  = ctrl_q.memwrite;
    assign Beq_if    = ctrl_q.beq;
    assign Bgezal_if = ctrl_q.bgezal;
    assign ALUOp     = ctrl_q.aluop;
    assign EXTOp     = ctrl_q.extop;

endmodule

// File: tb/tb_control.sv
// Directed bench for the control decoder: reset, each instruction class,
// funct masking, unknown encodings and asynchronous reset.
module tb_control;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       Jr_if, Bne_if, J_if, ALUSrc, RegWrite, MemWrite, Beq_if, Bgezal_if;
    logic [1:0] RegDst, MemtoReg, EXTOp;
    logic [2:0] ALUOp;

    int total = 0;
    int bad   = 0;

    control dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .Jr_if     (Jr_if),
        .Bne_if    (Bne_if),
        .J_if      (J_if),
        .RegDst    (RegDst),
        .ALUSrc    (ALUSrc),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .Beq_if    (Beq_if),
        .Bgezal_if (Bgezal_if),
        .ALUOp     (ALUOp),
        .EXTOp     (EXTOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed word, field order: Jr Bne J RegDst ALUSrc MemtoReg RegWrite MemWrite Beq Bgezal ALUOp EXTOp
    logic [16:0] obs;
    assign obs = {Jr_if, Bne_if, J_if, RegDst, ALUSrc, MemtoReg, RegWrite,
                  MemWrite, Beq_if, Bgezal_if, ALUOp, EXTOp};

    function automatic logic [16:0] mkw(input logic jr, input logic bne, input logic j,
                                        input logic [1:0] rd, input logic as, input logic [1:0] m2r,
                                        input logic rw, input logic mw, input logic beq,
                                        input logic bgz, input logic [2:0] alu, input logic [1:0] ext);
        return {jr, bne, j, rd, as, m2r, rw, mw, beq, bgz, alu, ext};
    endfunction

    localparam logic [16:0] W_NOP    = 17'b0;
    logic [16:0] w_lw, w_sw, w_ori, w_lui, w_beq, w_bne, w_j, w_jal, w_jr, w_jalr;
    logic [16:0] w_addu, w_subu, w_bgezal;

    task automatic apply(input logic [5:0] o, input logic [5:0] f);
        @(negedge clk);
        op    = o;
        funct = f;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        op    = 6'b100011;
        funct = 6'b000000;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs !== W_NOP) begin bad++; $display("FAIL reset_hold got=%b exp=%b", obs, W_NOP); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (obs !== W_NOP) begin bad++; $display("FAIL reset_release_noedge got=%b exp=%b", obs, W_NOP); end
        @(posedge clk);
        #1;
        total++;
        if (obs !== w_lw) begin bad++; $display("FAIL reset_first_lw got=%b exp=%b", obs, w_lw); end
    endtask

    task automatic test_jump_funct_ignored;
        apply(6'b000010, 6'b100001);
        total++;
        if (obs !== w_j) begin bad++; $display("FAIL j_funct_ignored got=%b exp=%b", obs, w_j); end
    endtask

    task automatic test_jal_jr;
        apply(6'b000011, 6'b000000);
        total++;
        if (obs !== w_jal) begin bad++; $display("FAIL jal got=%b exp=%b", obs, w_jal); end
        apply(6'b000000, 6'b001000);
        total++;
        if (obs !== w_jr) begin bad++; $display("FAIL jr got=%b exp=%b", obs, w_jr); end
        apply(6'b000000, 6'b001001);
        total++;
        if (obs !== w_jalr) begin bad++; $display("FAIL jalr got=%b exp=%b", obs, w_jalr); end
    endtask

    task automatic test_back_to_back;
        apply(6'b000000, 6'b100001);
        total++;
        if (obs !== w_addu) begin bad++; $display("FAIL addu got=%b exp=%b", obs, w_addu); end
        apply(6'b000000, 6'b100011);
        total++;
        if (obs !== w_subu) begin bad++; $display("FAIL subu got=%b exp=%b", obs, w_subu); end
    endtask

    task automatic test_imm_mem;
        apply(6'b001101, 6'b111111);
        total++;
        if (obs !== w_ori) begin bad++; $display("FAIL ori got=%b exp=%b", obs, w_ori); end
        apply(6'b001111, 6'b000000);
        total++;
        if (obs !== w_lui) begin bad++; $display("FAIL lui got=%b exp=%b", obs, w_lui); end
        apply(6'b101011, 6'b000000);
        total++;
        if (obs !== w_sw) begin bad++; $display("FAIL sw got=%b exp=%b", obs, w_sw); end
        apply(6'b100011, 6'b001000);
        total++;
        if (obs !== w_lw) begin bad++; $display("FAIL lw got=%b exp=%b", obs, w_lw); end
    endtask

    task automatic test_branches;
        apply(6'b000100, 6'b000000);
        total++;
        if (obs !== w_beq) begin bad++; $display("FAIL beq got=%b exp=%b", obs, w_beq); end
        apply(6'b000101, 6'b000000);
        total++;
        if (obs !== w_bne) begin bad++; $display("FAIL bne got=%b exp=%b", obs, w_bne); end
        apply(6'b000001, 6'b100011);
        total++;
        if (obs !== w_bgezal) begin bad++; $display("FAIL bgezal got=%b exp=%b", obs, w_bgezal); end
    endtask

    task automatic test_hold;
        apply(6'b000011, 6'b000000);
        @(negedge clk);
        op    = 6'b101011;
        funct = 6'b000000;
        #2;
        total++;
        if (obs !== w_jal) begin bad++; $display("FAIL hold_between_edges got=%b exp=%b", obs, w_jal); end
        @(posedge clk);
        #1;
        total++;
        if (obs !== w_sw) begin bad++; $display("FAIL hold_next_edge got=%b exp=%b", obs, w_sw); end
    endtask

    task automatic test_unknown;
        apply(6'b000000, 6'b000000);
        total++;
        if (obs !== W_NOP) begin bad++; $display("FAIL sll_nop got=%b exp=%b", obs, W_NOP); end
        apply(6'b000011, 6'b000000);
        apply(6'b111111, 6'b100001);
        total++;
        if (obs !== W_NOP) begin bad++; $display("FAIL unknown_op got=%b exp=%b", obs, W_NOP); end
        apply(6'b000011, 6'b000000);
        apply(6'b000000, 6'b111111);
        total++;
        if (obs !== W_NOP) begin bad++; $display("FAIL unknown_funct got=%b exp=%b", obs, W_NOP); end
    endtask

    task automatic test_async_reset;
        apply(6'b000011, 6'b000000);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (obs !== W_NOP) begin bad++; $display("FAIL async_reset got=%b exp=%b", obs, W_NOP); end
        @(negedge clk);
        op    = 6'b001111;
        reset = 1'b0;
        #1;
        total++;
        if (obs !== W_NOP) begin bad++; $display("FAIL async_reset_stays got=%b exp=%b", obs, W_NOP); end
        @(posedge clk);
        #1;
        total++;
        if (obs !== w_lui) begin bad++; $display("FAIL post_reset_decode got=%b exp=%b", obs, w_lui); end
    endtask

    initial begin
        //              jr   bne  j    rd     as   m2r    rw   mw   beq  bgz  alu     ext
        w_lw     = mkw(1'b0,1'b0,1'b0,2'b00,1'b1,2'b01,1'b1,1'b0,1'b0,1'b0,3'b000,2'b01);
        w_sw     = mkw(1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,1'b0,1'b1,1'b0,1'b0,3'b000,2'b01);
        w_ori    = mkw(1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,1'b1,1'b0,1'b0,1'b0,3'b010,2'b00);
        w_lui    = mkw(1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,1'b1,1'b0,1'b0,1'b0,3'b011,2'b10);
        w_beq    = mkw(1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,3'b001,2'b01);
        w_bne    = mkw(1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,3'b001,2'b01);
        w_j      = mkw(1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,3'b000,2'b00);
        w_jal    = mkw(1'b0,1'b0,1'b1,2'b10,1'b0,2'b10,1'b1,1'b0,1'b0,1'b0,3'b000,2'b00);
        w_jr     = mkw(1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,3'b000,2'b00);
        w_jalr   = mkw(1'b1,1'b0,1'b0,2'b01,1'b0,2'b10,1'b1,1'b0,1'b0,1'b0,3'b000,2'b00);
        w_addu   = mkw(1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,3'b000,2'b00);
        w_subu   = mkw(1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,3'b001,2'b00);
        w_bgezal = mkw(1'b0,1'b0,1'b0,2'b10,1'b0,2'b10,1'b1,1'b0,1'b0,1'b1,3'b000,2'b01);

        reset = 1'b1;
        op    = '0;
        funct = '0;

        test_reset();
        test_jump_funct_ignored();
        test_jal_jr();
        test_back_to_back();
        test_imm_mem();
        test_branches();
        test_hold();
        test_unknown();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
